ram_256x8: RTL and testbench

- Single-port synchronous 256 x 8 RAM that holds character and command bytes for the LCD text path.
- The display controller drives an address, and the RAM returns the byte one clock later.
- After reset, a built-in clear sequencer fills every location with a fill byte (ASCII space) so the display shows a blank screen until text is written.
- Sits between the text producer (write side) and the LCD display FSM (read side).

---
 rtl/ram_256x8_pkg.sv | 18 +
 rtl/ram_256x8_if.sv | 22 ++
 rtl/ram_core_sp.sv | 33 +++
 rtl/ram_256x8.sv | 83 ++++++++
 tb/tb_ram_256x8.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/ram_256x8_pkg.sv
// Shared constants and types for the LCD text RAM: geometry, fill character
// and the post-reset clear sequencer states.
package ram_256x8_pkg;

  localparam int          RAM_ADDR_W    = 8;
  localparam int          RAM_DATA_W    = 8;
  localparam logic [7:0]  LCD_FILL_CHAR = 8'h20;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } seq_state_e;

  function automatic int ram_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_256x8_if.sv
// Access port of the LCD text RAM: write side from the text producer, read
// side toward the display FSM, plus the clear-in-progress flag.
interface ram_256x8_if;
  import ram_256x8_pkg::*;

  logic                  write;
  logic [RAM_ADDR_W-1:0] addr;
  logic [RAM_DATA_W-1:0] din;
  logic [RAM_DATA_W-1:0] dout;
  logic                  init_busy;

  modport master (
    output write, addr, din,
    input  dout, init_busy
  );

  modport slave (
    input  write, addr, din,
    output dout, init_busy
  );

endinterface

// File: rtl/ram_core_sp.sv
// Plain single-port inferred RAM with a registered, read-first output so the
// array maps onto a block RAM primitive.
module ram_core_sp
  import ram_256x8_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  localparam int DEPTH = ram_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;

  // NOTE: the array and its read register carry no reset; a reset would stop
  // the tools from mapping them onto block RAM. Contents are initialised by
  // the clear sequencer through the write port instead.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
    dout_q <= mem_q[addr_i];
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/ram_256x8.sv
// LCD text RAM top: after reset a sequencer fills every location with the fill
// character through the normal write port, then hands the port to the user.
module ram_256x8
  import ram_256x8_pkg::*;
#(
  parameter int              ADDR_W   = RAM_ADDR_W,
  parameter int              DATA_W   = RAM_DATA_W,
  parameter logic [DATA_W-1:0] FILL_VAL = LCD_FILL_CHAR
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_256x8_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  seq_state_e        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;
  logic              rd_ok_q;

  logic              clearing;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_din;
  logic [DATA_W-1:0] core_dout;

  // NOTE: every register here is assigned with <= so all state updates see
  // the pre-edge values, matching the hardware regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      rd_ok_q <= 1'b0;
    end else begin
      // The read captured on this edge belongs to the user only if the port
      // was already handed over when the edge arrived.
      rd_ok_q <= (state_q == READY);
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LAST_ADDR) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          ptr_q <= '0;
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Port mux: the sequencer owns the RAM while clearing, so user writes are
  // dropped and a reset asserted mid-write cancels it immediately.
  assign clearing  = (state_q == CLEAR);
  assign core_we   = clearing ? 1'b1     : bus.write;
  assign core_addr = clearing ? ptr_q    : bus.addr;
  assign core_din  = clearing ? FILL_VAL : bus.din;

  ram_core_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_core (
    .clk    (clk),
    .we_i   (core_we),
    .addr_i (core_addr),
    .din_i  (core_din),
    .dout_o (core_dout)
  );

  // The core read register has no reset; qualifying it with a reset flop
  // gives dout = 0 during reset and clear without touching the block RAM.
  assign bus.dout      = rd_ok_q ? core_dout : '0;
  assign bus.init_busy = busy_q;

endmodule

// File: tb/tb_ram_256x8.sv
// Scoreboard bench for the LCD text RAM: stimulus queues expected read data,
// a monitor pops and compares one cycle after each issued read.
module tb_ram_256x8;
  import ram_256x8_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_256x8_if bus ();

  ram_256x8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic rd_issue = 1'b0;
  logic rd_tag   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a read issued on an edge is compared on the following negedge.
  always @(posedge clk) rd_tag <= rd_issue;

  always @(negedge clk) begin
    exp_t e;
    if (rd_tag) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check(e.name, 32'(bus.dout), 32'(e.exp));
      end
    end
  end

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
    bus.write = 1'b0;
    bus.addr  = a;
    rd_issue  = 1'b1;
    sb_q.push_back('{nm, e});
    @(posedge clk); #1;
    rd_issue  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.write = 1'b1;
    bus.addr  = a;
    bus.din   = d;
    rd_issue  = 1'b0;
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic wr_rd(input logic [7:0] a, input logic [7:0] d, input logic [7:0] e,
                       input string nm);
    bus.write = 1'b1;
    bus.addr  = a;
    bus.din   = d;
    rd_issue  = 1'b1;
    sb_q.push_back('{nm, e});
    @(posedge clk); #1;
    bus.write = 1'b0;
    rd_issue  = 1'b0;
  endtask

  // Counts edges until init_busy falls (bounded) and watches dout meanwhile.
  task automatic wait_clear(input string nm);
    int   n       = 0;
    logic dout_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      if (bus.dout !== 8'h00) dout_ok = 1'b0;
    end while (bus.init_busy === 1'b1 && n < 400);
    check({nm, "_busy_cycles"}, 32'(n), 32'd256);
    check({nm, "_dout_zero"}, 32'(dout_ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.write = 1'b0;
    bus.addr  = '0;
    bus.din   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 32'(bus.dout), 32'h00);
    check("reset_busy", 32'(bus.init_busy), 32'd1);

    // Release reset with a write held for the whole clear; it must be ignored.
    @(negedge clk);
    bus.write = 1'b1;
    bus.addr  = 8'h10;
    bus.din   = 8'hAA;
    rst_n     = 1'b1;
    wait_clear("clear1");
    bus.write = 1'b0;
    check("busy_low", 32'(bus.init_busy), 32'd0);

    rd(8'h00, 8'h20, "fill_00");
    rd(8'h11, 8'h20, "fill_11");
    rd(8'hFF, 8'h20, "fill_ff");
    rd(8'h10, 8'h20, "wr_during_clear");

    wr(8'h01, 8'h48);
    wr(8'h02, 8'h65);
    rd(8'h01, 8'h48, "rd_01");
    rd(8'h02, 8'h65, "rd_02");

    wr(8'h05, 8'h41);
    wr_rd(8'h05, 8'h42, 8'h41, "rdw_old");
    rd(8'h05, 8'h42, "rdw_new");

    wr(8'h20, 8'h55);
    rd(8'h20, 8'h55, "rd_20");
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_dout", 32'(bus.dout), 32'h00);
    check("async_busy", 32'(bus.init_busy), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("clear2");
    rd(8'h20, 8'h20, "post_reset_20");

    for (int i = 0; i < 256; i++) wr(i[7:0], i[7:0] ^ 8'hC3);
    for (int i = 0; i < 256; i++) rd(i[7:0], i[7:0] ^ 8'hC3, $sformatf("sweep_%02h", i));

    @(negedge clk);
    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
